// File: rtl/dbg_disp_pkg.sv
// Shared types and constants for the debug probe display.
package dbg_disp_pkg;

    typedef enum logic [1:0] {
        DM_LIVE   = 2'b00,
        DM_CAPT   = 2'b01,
        DM_FREEZE = 2'b10,
        DM_SCROLL = 2'b11
    } dbg_mode_e;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned CNT_W      = 8;

    // One enable bit per nibble actually carried by a probe word, right-aligned.
    function automatic logic [NUM_DIGITS-1:0] nibble_mask(input int unsigned data_w);
        logic [NUM_DIGITS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (i < data_w / 4) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/dbg_capture_ch.sv
// One probe channel: strobe rising-edge detect, captured word, valid flag and
// saturating edge count.
module dbg_capture_ch
    import dbg_disp_pkg::*;
#(
    parameter int unsigned DATA_W = 24
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              strobe,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] cap,
    output logic              valid,
    output logic [CNT_W-1:0]  cnt
);

    logic              strobe_prev_q, strobe_prev_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              edge_c;

    always_comb begin
        strobe_prev_d = strobe;
        cap_d         = cap_q;
        valid_d       = valid_q;
        cnt_d         = cnt_q;
        edge_c        = strobe & ~strobe_prev_q;
        if (edge_c) begin
            cap_d   = data;
            valid_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            strobe_prev_q <= 1'b0;
            cap_q         <= '0;
            valid_q       <= 1'b0;
            cnt_q         <= '0;
        end else begin
            strobe_prev_q <= strobe_prev_d;
            cap_q         <= cap_d;
            valid_q       <= valid_d;
            cnt_q         <= cnt_d;
        end
    end

    assign cap   = cap_q;
    assign valid = valid_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/dbg_probe_display.sv
// Debug probe display: live / capture / freeze / auto-scroll views of NUM_CH
// probe words onto six hex digits. Auto-scroll needs DBG_DISP_AUTOSCROLL_EN.
module dbg_probe_display
    import dbg_disp_pkg::*;
#(
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned SCROLL_DIV = 50_000_000,
    parameter int unsigned CH_W       = $clog2(NUM_CH)
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_strobe,
    input  logic [CH_W-1:0]          sel,
    input  logic [1:0]               mode,
    output logic [NUM_DIGITS*4-1:0]  hex_digits,
    output logic [NUM_DIGITS-1:0]    digit_en,
    output logic [CH_W-1:0]          cur_ch,
    output logic                     capt_valid,
    output logic [CNT_W-1:0]         capt_count
);

    localparam int unsigned HEX_W = NUM_DIGITS * 4;

    logic [DATA_W-1:0] live_w [NUM_CH];
    logic [DATA_W-1:0] cap_w  [NUM_CH];
    logic [CNT_W-1:0]  cnt_w  [NUM_CH];
    logic [NUM_CH-1:0] valid_w;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign live_w[i] = ch_data[i*DATA_W +: DATA_W];

        dbg_capture_ch #(
            .DATA_W (DATA_W)
        ) u_cap (
            .Clk    (Clk),
            .Reset  (Reset),
            .strobe (ch_strobe[i]),
            .data   (live_w[i]),
            .cap    (cap_w[i]),
            .valid  (valid_w[i]),
            .cnt    (cnt_w[i])
        );
    end

    logic [CH_W-1:0]       sel_eff_c;
    dbg_mode_e             mode_c;
    logic [CH_W-1:0]       cur_ch_q, cur_ch_d;
    logic [HEX_W-1:0]      hex_q, hex_d;
    logic [NUM_DIGITS-1:0] den_q, den_d;
    logic                  cv_q, cv_d;
    logic [CNT_W-1:0]      cc_q, cc_d;

`ifdef DBG_DISP_AUTOSCROLL_EN
    localparam int unsigned SC_W = $clog2(SCROLL_DIV);
    logic [SC_W-1:0] scnt_q, scnt_d;
    dbg_mode_e       mode_prev_q, mode_prev_d;
`endif

    assign mode_c = dbg_mode_e'(mode);

    // Out-of-range selects land on the last channel.
    always_comb begin
        sel_eff_c = sel;
        if (32'(sel) >= NUM_CH) begin
            sel_eff_c = CH_W'(NUM_CH - 1);
        end
    end

    // Registers: display outputs, mode history and scroll counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cur_ch_q    <= '0;
            hex_q       <= '0;
            den_q       <= '0;
            cv_q        <= 1'b0;
            cc_q        <= '0;
`ifdef DBG_DISP_AUTOSCROLL_EN
            scnt_q      <= '0;
            mode_prev_q <= DM_LIVE;
`endif
        end else begin
            cur_ch_q    <= cur_ch_d;
            hex_q       <= hex_d;
            den_q       <= den_d;
            cv_q        <= cv_d;
            cc_q        <= cc_d;
`ifdef DBG_DISP_AUTOSCROLL_EN
            scnt_q      <= scnt_d;
            mode_prev_q <= mode_prev_d;
`endif
        end
    end

    // Next displayed channel per mode.
    always_comb begin
        cur_ch_d = cur_ch_q;
`ifdef DBG_DISP_AUTOSCROLL_EN
        scnt_d      = '0;
        mode_prev_d = mode_c;
`endif
        case (mode_c)
            DM_FREEZE: cur_ch_d = cur_ch_q;
`ifdef DBG_DISP_AUTOSCROLL_EN
            DM_SCROLL: begin
                if (mode_prev_q != DM_SCROLL) begin
                    cur_ch_d = sel_eff_c;
                end else if (scnt_q == SC_W'(SCROLL_DIV - 1)) begin
                    cur_ch_d = (cur_ch_q == CH_W'(NUM_CH - 1)) ? '0 : cur_ch_q + CH_W'(1);
                end else begin
                    scnt_d = scnt_q + SC_W'(1);
                end
            end
`endif
            default:   cur_ch_d = sel_eff_c;
        endcase
    end

    // Output values; freeze simply keeps every output register loaded.
    always_comb begin
        hex_d = hex_q;
        den_d = den_q;
        cv_d  = cv_q;
        cc_d  = cc_q;
        if (mode_c != DM_FREEZE) begin
            den_d = nibble_mask(DATA_W);
            cv_d  = valid_w[cur_ch_d];
            cc_d  = cnt_w[cur_ch_d];
            if (mode_c == DM_CAPT) begin
                hex_d = HEX_W'(cap_w[cur_ch_d]);
            end else begin
                hex_d = HEX_W'(live_w[cur_ch_d]);
            end
        end
    end

    assign hex_digits = hex_q;
    assign digit_en   = den_q;
    assign cur_ch     = cur_ch_q;
    assign capt_valid = cv_q;
    assign capt_count = cc_q;

endmodule

// File: tb/tb_dbg_probe_display.sv
// Scoreboard bench for dbg_probe_display (8x24 instance plus a 6x16 instance).
module tb_dbg_probe_display;

    localparam logic [4:0] M_HEX = 5'b00001;
    localparam logic [4:0] M_DEN = 5'b00010;
    localparam logic [4:0] M_CH  = 5'b00100;
    localparam logic [4:0] M_V   = 5'b01000;
    localparam logic [4:0] M_CNT = 5'b10000;
    localparam logic [4:0] M_ALL = 5'b11111;

    typedef struct {
        string       name;
        bit          d6;
        logic [23:0] hex;
        logic [5:0]  den;
        logic [2:0]  ch;
        logic        v;
        logic [7:0]  cnt;
        logic [4:0]  m;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic [191:0] ch_data;
    logic [7:0]   ch_strobe;
    logic [2:0]   sel;
    logic [1:0]   mode;
    logic [23:0]  hex8;
    logic [5:0]   den8;
    logic [2:0]   cur8;
    logic         cv8;
    logic [7:0]   cc8;

    logic [95:0]  ch_data6;
    logic [5:0]   ch_strobe6;
    logic [2:0]   sel6;
    logic [1:0]   mode6;
    logic [23:0]  hex6;
    logic [5:0]   den6;
    logic [2:0]   cur6;
    logic         cv6;
    logic [7:0]   cc6;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    dbg_probe_display #(.NUM_CH(8), .DATA_W(24), .SCROLL_DIV(4)) u_dut (
        .Clk(clk), .Reset(rst), .ch_data(ch_data), .ch_strobe(ch_strobe),
        .sel(sel), .mode(mode), .hex_digits(hex8), .digit_en(den8),
        .cur_ch(cur8), .capt_valid(cv8), .capt_count(cc8)
    );

    dbg_probe_display #(.NUM_CH(6), .DATA_W(16), .SCROLL_DIV(4)) u_dut6 (
        .Clk(clk), .Reset(rst), .ch_data(ch_data6), .ch_strobe(ch_strobe6),
        .sel(sel6), .mode(mode6), .hex_digits(hex6), .digit_en(den6),
        .cur_ch(cur6), .capt_valid(cv6), .capt_count(cc6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input bit d6, input logic [23:0] hex,
                        input logic [5:0] den, input logic [2:0] ch, input logic v,
                        input logic [7:0] cnt, input logic [4:0] m);
        exp_t e;
        e.name = name; e.d6 = d6; e.hex = hex; e.den = den;
        e.ch = ch; e.v = v; e.cnt = cnt; e.m = m;
        exp_q.push_back(e);
    endtask

    task automatic set_ch(input int i, input logic [23:0] val);
        ch_data[i*24 +: 24] = val;
    endtask

    task automatic set_ch6(input int i, input logic [15:0] val);
        ch_data6[i*16 +: 16] = val;
    endtask

    // Monitor: compare every pending expectation against the sampled outputs.
    exp_t        me;
    bit          mbad;
    logic [23:0] a_hex;
    logic [5:0]  a_den;
    logic [2:0]  a_ch;
    logic        a_v;
    logic [7:0]  a_cnt;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            me    = exp_q.pop_front();
            mbad  = 1'b0;
            n_vec = n_vec + 1;
            a_hex = me.d6 ? hex6 : hex8;
            a_den = me.d6 ? den6 : den8;
            a_ch  = me.d6 ? cur6 : cur8;
            a_v   = me.d6 ? cv6  : cv8;
            a_cnt = me.d6 ? cc6  : cc8;
            if ((me.m & M_HEX) != 0 && a_hex !== me.hex) begin
                $display("FAIL %s hex_digits got %h expected %h", me.name, a_hex, me.hex); mbad = 1'b1;
            end
            if ((me.m & M_DEN) != 0 && a_den !== me.den) begin
                $display("FAIL %s digit_en got %b expected %b", me.name, a_den, me.den); mbad = 1'b1;
            end
            if ((me.m & M_CH) != 0 && a_ch !== me.ch) begin
                $display("FAIL %s cur_ch got %0d expected %0d", me.name, a_ch, me.ch); mbad = 1'b1;
            end
            if ((me.m & M_V) != 0 && a_v !== me.v) begin
                $display("FAIL %s capt_valid got %b expected %b", me.name, a_v, me.v); mbad = 1'b1;
            end
            if ((me.m & M_CNT) != 0 && a_cnt !== me.cnt) begin
                $display("FAIL %s capt_count got %0d expected %0d", me.name, a_cnt, me.cnt); mbad = 1'b1;
            end
            if (mbad) n_miss = n_miss + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        logic [2:0] c3;
        rst = 1'b1; ch_data = '0; ch_strobe = '0; sel = '0; mode = 2'b00;
        ch_data6 = '0; ch_strobe6 = '0; sel6 = '0; mode6 = 2'b00;
        tick(); tick();
        push("reset", 1'b0, 24'h0, 6'h00, 3'd0, 1'b0, 8'd0, M_ALL);
        push("reset6", 1'b1, 24'h0, 6'h00, 3'd0, 1'b0, 8'd0, M_ALL);
        rst = 1'b0;
        tick();

        // Live view and the narrow instance with select clamp.
        sel = 3'd2; set_ch(2, 24'hABCDEF);
        sel6 = 3'd7; set_ch6(5, 16'hBEEF);
        tick();
        push("live", 1'b0, 24'hABCDEF, 6'b111111, 3'd2, 1'b0, 8'd0, M_ALL);
        push("clamp6", 1'b1, 24'h00BEEF, 6'b001111, 3'd5, 1'b0, 8'd0, M_ALL);
        sel6 = 3'd4; set_ch6(4, 16'h1234);
        tick();
        push("live6", 1'b1, 24'h001234, 6'b001111, 3'd4, 1'b0, 8'd0, M_ALL);

        // Single-cycle strobe capture on ch1.
        mode = 2'b01; sel = 3'd1; set_ch(1, 24'h000123); ch_strobe[1] = 1'b1;
        tick();
        push("capt_edge", 1'b0, 24'h000000, 6'b111111, 3'd1, 1'b0, 8'd0, M_ALL);
        ch_strobe[1] = 1'b0; set_ch(1, 24'h000456);
        tick();
        push("capt_show", 1'b0, 24'h000123, 6'b111111, 3'd1, 1'b1, 8'd1, M_ALL);
        tick();
        push("capt_keep", 1'b0, 24'h000123, 6'b111111, 3'd1, 1'b1, 8'd1, M_ALL);

        // Strobe held high for six cycles captures once.
        sel = 3'd3; set_ch(3, 24'h000AAA); ch_strobe[3] = 1'b1;
        tick();
        set_ch(3, 24'h000BBB);
        repeat (5) tick();
        ch_strobe[3] = 1'b0;
        tick();
        push("capt_held", 1'b0, 24'h000AAA, 6'b111111, 3'd3, 1'b1, 8'd1, M_ALL);

        // Saturating edge count on ch0.
        sel = 3'd0; set_ch(0, 24'h5A5A5A);
        for (int p = 1; p <= 300; p++) begin
            ch_strobe[0] = 1'b1; tick();
            ch_strobe[0] = 1'b0; tick();
            if (p == 254) push("sat254", 1'b0, 24'h5A5A5A, 6'b111111, 3'd0, 1'b1, 8'd254, M_ALL);
            if (p == 255) push("sat255", 1'b0, 24'h5A5A5A, 6'b111111, 3'd0, 1'b1, 8'd255, M_ALL);
            if (p == 300) push("sat300", 1'b0, 24'h5A5A5A, 6'b111111, 3'd0, 1'b1, 8'd255, M_ALL);
        end

        // Freeze holds outputs while capture continues underneath.
        mode = 2'b00; sel = 3'd4; set_ch(4, 24'h111111);
        tick();
        push("pre_frz", 1'b0, 24'h111111, 6'b111111, 3'd4, 1'b0, 8'd0, M_ALL);
        mode = 2'b10; set_ch(4, 24'h222222); sel = 3'd5; set_ch(5, 24'h333333);
        tick();
        push("frz_hold", 1'b0, 24'h111111, 6'b111111, 3'd4, 1'b0, 8'd0, M_ALL);
        ch_strobe[4] = 1'b1;
        tick();
        push("frz_strb", 1'b0, 24'h111111, 6'b111111, 3'd4, 1'b0, 8'd0, M_ALL);
        ch_strobe[4] = 1'b0;
        tick();
        push("frz_hold2", 1'b0, 24'h111111, 6'b111111, 3'd4, 1'b0, 8'd0, M_ALL);
        mode = 2'b00;
        tick();
        push("unfrz", 1'b0, 24'h333333, 6'b111111, 3'd5, 1'b0, 8'd0, M_ALL);
        sel = 3'd4;
        tick();
        push("bg_capt", 1'b0, 24'h222222, 6'b111111, 3'd4, 1'b1, 8'd1, M_ALL);

        // Auto-scroll from channel 6.
        for (int k = 0; k < 8; k++) set_ch(k, {4'hC, 20'(k)});
        mode = 2'b11; sel = 3'd6;
        tick();
        push("scr_entry", 1'b0, 24'hC00006, 6'b111111, 3'd6, 1'b0, 8'd0, M_HEX | M_DEN | M_CH);
        for (int j = 1; j <= 15; j++) begin
            tick();
`ifdef DBG_DISP_AUTOSCROLL_EN
            c = (6 + j / 4) % 8;
`else
            c = 6;
`endif
            c3 = 3'(c);
            push($sformatf("scr_%0d", j), 1'b0, {4'hC, 20'(c3)}, 6'b111111, c3, 1'b0, 8'd0, M_HEX | M_CH);
        end

        // Reset coincides with a strobe edge and a scroll wrap.
        rst = 1'b1; ch_strobe[2] = 1'b1;
        tick();
        push("rst_mid", 1'b0, 24'h0, 6'h00, 3'd0, 1'b0, 8'd0, M_ALL);
        push("rst_mid6", 1'b1, 24'h0, 6'h00, 3'd0, 1'b0, 8'd0, M_ALL);
        rst = 1'b0; mode = 2'b01; sel = 3'd2;
        tick();
        push("post_rst", 1'b0, 24'h000000, 6'b111111, 3'd2, 1'b0, 8'd0, M_ALL);
        ch_strobe[2] = 1'b0;
        tick();
        push("post_rst_edge", 1'b0, 24'hC00002, 6'b111111, 3'd2, 1'b1, 8'd1, M_ALL);

        repeat (3) tick();
        if (exp_q.size() != 0) begin
            $display("FAIL drain %0d expectations never compared", exp_q.size());
            n_miss = n_miss + 1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
